sram_responder: RTL



---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_read_pipe.sv | 48 ++++
 rtl/sram_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared SRAM port widths and responder FSM state encoding.
// Revision : 1.0
// ============================================================================
package sram_pkg;

    localparam int c_addr_width = 10;
    localparam int c_data_width = 32;
    localparam int c_mask_width = c_data_width / 8;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_WBUSY   = 2'd2,
        ST_REFRESH = 2'd3
    } sram_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_read_pipe
// Purpose  : Valid/data delay line; data only advances behind a valid beat.
// Revision : 1.0
// ============================================================================
module sram_read_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0] r_valid;
            logic [WIDTH-1:0] r_data [DEPTH];

            // Data stages only load behind a valid beat, so the tail holds the last read word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
                end else begin
                    r_valid[0] <= in_valid;
                    if (in_valid) r_data[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        if (r_valid[i-1]) r_data[i] <= r_data[i-1];
                    end
                end
            end

            assign out_valid = r_valid[DEPTH-1];
            assign out_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : On-chip SRAM backing store with byte-masked writes, pipelined
//            in-order reads, write recovery and periodic refresh throttling.
// Revision : 1.0
// ============================================================================
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_addr_width,
    parameter int DATA_WIDTH     = c_data_width,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 3,
    parameter int WRITE_BUSY     = 1,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                  sram_clock,
    input  logic                  reset,
    input  logic                  sram_addr_valid,
    output logic                  sram_ready,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [MASK_WIDTH-1:0] sram_write_mask,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_data_out_valid,
    output logic [1:0]            state
);

    localparam int c_hold_max = (WRITE_BUSY > REFRESH_CYCLES) ? WRITE_BUSY : REFRESH_CYCLES;
    localparam int c_cnt_w    = $clog2(c_hold_max + 1);
    localparam int c_ref_w    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    localparam logic [c_cnt_w-1:0] c_busy_load = c_cnt_w'((WRITE_BUSY > 0) ? WRITE_BUSY - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_ref_load  = c_cnt_w'(REFRESH_CYCLES - 1);
    localparam logic [c_ref_w-1:0] c_ref_last  = c_ref_w'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);

    sram_state_e           r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_ref_w-1:0]    r_ref_cnt;
    logic                  r_ref_pending;
    logic                  r_cmd_valid;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH) - 1];

    logic w_accept;
    logic w_write;

    assign sram_ready = (r_state == ST_ACCEPT) && !r_ref_pending;
    assign w_accept   = sram_addr_valid && sram_ready && !reset;
    assign w_write    = |sram_write_mask;
    assign state      = r_state;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_state       <= ST_RESET;
            r_cnt         <= '0;
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_ACCEPT;
                ST_ACCEPT: begin
                    if (r_ref_pending) begin
                        r_state       <= ST_REFRESH;
                        r_cnt         <= c_ref_load;
                        r_ref_pending <= 1'b0;
                    end else if (w_accept && w_write && (WRITE_BUSY > 0)) begin
                        r_state <= ST_WBUSY;
                        r_cnt   <= c_busy_load;
                    end
                end
                ST_WBUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end else if (r_ref_pending) begin
                        r_state       <= ST_REFRESH;
                        r_cnt         <= c_ref_load;
                        r_ref_pending <= 1'b0;
                    end else begin
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_REFRESH: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_w'(1);
                    else             r_state <= ST_ACCEPT;
                end
                default: r_state <= ST_RESET;
            endcase

            // Placed after the FSM so a new request on the refresh-entry edge is not lost.
            if ((REFRESH_PERIOD != 0) && (r_state != ST_RESET)) begin
                if (r_ref_cnt == c_ref_last) begin
                    r_ref_cnt     <= '0;
                    r_ref_pending <= 1'b1;
                end else begin
                    r_ref_cnt <= r_ref_cnt + c_ref_w'(1);
                end
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        if (w_accept && w_write) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (sram_write_mask[b]) r_mem[sram_addr][8*b +: 8] <= sram_data_in[8*b +: 8];
            end
        end
    end

    // The address is registered and the array read one edge later; a write on that
    // later edge is not visible, so the word matches the array at the accept edge.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_cmd_valid <= w_accept && !w_write;
            if (w_accept && !w_write) r_cmd_addr <= sram_addr;
            r_rd_valid <= r_cmd_valid;
            if (r_cmd_valid) r_rd_data <= r_mem[r_cmd_addr];
        end
    end

    sram_read_pipe #(
        .DEPTH (READ_LATENCY - 1),
        .WIDTH (DATA_WIDTH)
    ) u_read_pipe (
        .clk       (sram_clock),
        .rst       (reset),
        .in_valid  (r_rd_valid),
        .in_data   (r_rd_data),
        .out_valid (sram_data_out_valid),
        .out_data  (sram_data_out)
    );

endmodule
`default_nettype wire
